// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - operand-read and writeback bus of the register file
// Decode drives RS/RT, writeback drives RD/RegWrite/WriteData; reads return on ReadRS/ReadRT.
interface register_file_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] RS;
  logic [ADDR_W-1:0] RT;
  logic [ADDR_W-1:0] RD;
  logic              RegWrite;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] ReadRS;
  logic [DATA_W-1:0] ReadRT;

  modport master (
    output RS, RT, RD, RegWrite, WriteData,
    input  ReadRS, ReadRT
  );

  modport slave (
    input  RS, RT, RD, RegWrite, WriteData,
    output ReadRS, ReadRT
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 8x16 register file, two combinational reads, one clocked write, R0 = 0
// Optional write-to-read forwarding on both ports when REGFILE_BYPASS_EN is defined.
module register_file #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic Clock,
  input  logic ResetN,
  register_file_if.slave rf
);
  localparam int DEPTH = 1 << ADDR_W;

  // R0 has no storage; index 0 only exists in the read view.
  logic [DATA_W-1:0] regs_q [DEPTH-1:1];
  logic [DATA_W-1:0] regs_d [DEPTH-1:1];
  logic [DATA_W-1:0] read_view [DEPTH];
  logic [DATA_W-1:0] read_rs;
  logic [DATA_W-1:0] read_rt;

  always_comb begin
    for (int i = 1; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (rf.RegWrite && (rf.RD == ADDR_W'(i))) begin
        regs_d[i] = rf.WriteData;
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    read_view[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      read_view[i] = regs_q[i];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd_valid;
  logic fwd_rs;
  logic fwd_rt;

  // Forward only a write that will actually land, and never during reset.
  always_comb begin
    fwd_valid = ResetN && rf.RegWrite && (rf.RD != '0);
    fwd_rs    = fwd_valid && (rf.RS == rf.RD);
    fwd_rt    = fwd_valid && (rf.RT == rf.RD);
    read_rs   = fwd_rs ? rf.WriteData : read_view[rf.RS];
    read_rt   = fwd_rt ? rf.WriteData : read_view[rf.RT];
  end
`else
  always_comb begin
    read_rs = read_view[rf.RS];
    read_rt = read_view[rf.RT];
  end
`endif

  assign rf.ReadRS = read_rs;
  assign rf.ReadRT = read_rt;
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
  logic Clock;
  logic ResetN;
  int   checks;
  int   errors;

  register_file_if #(.DATA_W(16), .ADDR_W(3)) rf_if ();

  register_file #(.DATA_W(16), .ADDR_W(3)) dut (
    .Clock  (Clock),
    .ResetN (ResetN),
    .rf     (rf_if)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] rd, input logic [15:0] data);
    rf_if.RD        = rd;
    rf_if.WriteData = data;
    rf_if.RegWrite  = 1'b1;
    tick();
    rf_if.RegWrite  = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 8; i++) begin
      rf_if.RS = 3'(i);
      rf_if.RT = 3'(7 - i);
      #1;
      checks++;
      if (rf_if.ReadRS !== 16'h0000 || rf_if.ReadRT !== 16'h0000) begin
        $display("FAIL reset_clear[%0d]: ReadRS=%h ReadRT=%h expected 0000 0000", i, rf_if.ReadRS, rf_if.ReadRT);
        errors++;
      end
    end
    ResetN = 1'b1;
    write_reg(3'd5, 16'h1234);
    rf_if.RS = 3'd5;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'h1234) begin
      $display("FAIL reset_prewrite: ReadRS=%h expected 1234", rf_if.ReadRS);
      errors++;
    end
    ResetN = 1'b0;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'h0000) begin
      $display("FAIL reset_async: ReadRS=%h expected 0000", rf_if.ReadRS);
      errors++;
    end
    rf_if.RD        = 3'd5;
    rf_if.WriteData = 16'hAAAA;
    rf_if.RegWrite  = 1'b1;
    rf_if.RT        = 3'd5;
    #1;
    checks++;
    if (rf_if.ReadRT !== 16'h0000) begin
      $display("FAIL reset_no_bypass: ReadRT=%h expected 0000", rf_if.ReadRT);
      errors++;
    end
    tick();
    checks++;
    if (rf_if.ReadRS !== 16'h0000) begin
      $display("FAIL reset_overrides_write: ReadRS=%h expected 0000", rf_if.ReadRS);
      errors++;
    end
    rf_if.RegWrite = 1'b0;
    ResetN = 1'b1;
    write_reg(3'd1, 16'h1111);
    rf_if.RS = 3'd1;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'h1111) begin
      $display("FAIL reset_first_write: ReadRS=%h expected 1111", rf_if.ReadRS);
      errors++;
    end
  endtask

  task automatic test_basic;
    write_reg(3'd2, 16'd5);
    write_reg(3'd3, 16'd7);
    rf_if.RS = 3'd2;
    rf_if.RT = 3'd3;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'd5 || rf_if.ReadRT !== 16'd7) begin
      $display("FAIL basic_rw: ReadRS=%h ReadRT=%h expected 0005 0007", rf_if.ReadRS, rf_if.ReadRT);
      errors++;
    end
  endtask

  task automatic test_r0;
    write_reg(3'd0, 16'hFFFF);
    rf_if.RS = 3'd0;
    rf_if.RT = 3'd1;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'h0000 || rf_if.ReadRT !== 16'h1111) begin
      $display("FAIL r0_hardwired: ReadRS=%h ReadRT=%h expected 0000 1111", rf_if.ReadRS, rf_if.ReadRT);
      errors++;
    end
    rf_if.RS = 3'd2;
    rf_if.RT = 3'd3;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'd5 || rf_if.ReadRT !== 16'd7) begin
      $display("FAIL r0_no_side_effect: ReadRS=%h ReadRT=%h expected 0005 0007", rf_if.ReadRS, rf_if.ReadRT);
      errors++;
    end
    // A pending R0 write must never be forwarded either.
    rf_if.RD        = 3'd0;
    rf_if.WriteData = 16'hDEAD;
    rf_if.RegWrite  = 1'b1;
    rf_if.RS        = 3'd0;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'h0000) begin
      $display("FAIL r0_no_forward: ReadRS=%h expected 0000", rf_if.ReadRS);
      errors++;
    end
    tick();
    rf_if.RegWrite = 1'b0;
  endtask

  task automatic test_write_disable;
    rf_if.RegWrite  = 1'b0;
    rf_if.RD        = 3'd4;
    rf_if.WriteData = 16'hBEEF;
    tick();
    rf_if.RS = 3'd4;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'h0000) begin
      $display("FAIL write_disable: ReadRS=%h expected 0000", rf_if.ReadRS);
      errors++;
    end
    rf_if.RD        = 'x;
    rf_if.WriteData = 'x;
    tick();
    rf_if.RS = 3'd2;
    rf_if.RT = 3'd3;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'd5 || rf_if.ReadRT !== 16'd7) begin
      $display("FAIL write_disable_x: ReadRS=%h ReadRT=%h expected 0005 0007", rf_if.ReadRS, rf_if.ReadRT);
      errors++;
    end
  endtask

  task automatic test_dual_port;
    logic [15:0] exp_pre;
    rf_if.RS = 3'd3;
    rf_if.RT = 3'd3;
    #1;
    checks++;
    if (rf_if.ReadRS !== 16'd7 || rf_if.ReadRT !== 16'd7) begin
      $display("FAIL dual_same_addr: ReadRS=%h ReadRT=%h expected 0007 0007", rf_if.ReadRS, rf_if.ReadRT);
      errors++;
    end
`ifdef REGFILE_BYPASS_EN
    exp_pre = 16'h8000;
`else
    exp_pre = 16'h0000;
`endif
    rf_if.RD        = 3'd7;
    rf_if.WriteData = 16'h8000;
    rf_if.RegWrite  = 1'b1;
    rf_if.RS        = 3'd7;
    #1;
    checks++;
    if (rf_if.ReadRS !== exp_pre || rf_if.ReadRT !== 16'd7) begin
      $display("FAIL dual_r7_pre: ReadRS=%h ReadRT=%h expected %h 0007", rf_if.ReadRS, rf_if.ReadRT, exp_pre);
      errors++;
    end
    tick();
    rf_if.RegWrite = 1'b0;
    checks++;
    if (rf_if.ReadRS !== 16'h8000) begin
      $display("FAIL dual_r7_post: ReadRS=%h expected 8000", rf_if.ReadRS);
      errors++;
    end
  endtask

  task automatic test_read_during_write;
    logic [15:0] exp_pre;
    write_reg(3'd6, 16'd1);
`ifdef REGFILE_BYPASS_EN
    exp_pre = 16'd9;
`else
    exp_pre = 16'd1;
`endif
    rf_if.RD        = 3'd6;
    rf_if.WriteData = 16'd9;
    rf_if.RegWrite  = 1'b1;
    rf_if.RS        = 3'd6;
    rf_if.RT        = 3'd6;
    #1;
    checks++;
    if (rf_if.ReadRS !== exp_pre || rf_if.ReadRT !== exp_pre) begin
      $display("FAIL rdw_pre: ReadRS=%h ReadRT=%h expected %h %h", rf_if.ReadRS, rf_if.ReadRT, exp_pre, exp_pre);
      errors++;
    end
    tick();
    rf_if.RegWrite = 1'b0;
    checks++;
    if (rf_if.ReadRS !== 16'd9 || rf_if.ReadRT !== 16'd9) begin
      $display("FAIL rdw_post: ReadRS=%h ReadRT=%h expected 0009 0009", rf_if.ReadRS, rf_if.ReadRT);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] vals [8];
    vals = '{16'h0000, 16'hA001, 16'h5A02, 16'h0F03, 16'hF004, 16'h1235, 16'hFFFF, 16'h8007};
    rf_if.RegWrite = 1'b1;
    for (int i = 1; i < 8; i++) begin
      rf_if.RD        = 3'(i);
      rf_if.WriteData = vals[i];
      tick();
    end
    rf_if.RegWrite = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rf_if.RS = 3'(i);
      rf_if.RT = 3'(7 - i);
      #1;
      checks++;
      if (rf_if.ReadRS !== vals[i] || rf_if.ReadRT !== vals[7 - i]) begin
        $display("FAIL b2b[%0d]: ReadRS=%h ReadRT=%h expected %h %h", i, rf_if.ReadRS, rf_if.ReadRT, vals[i], vals[7 - i]);
        errors++;
      end
    end
  endtask

  initial begin
    checks             = 0;
    errors             = 0;
    ResetN             = 1'b0;
    rf_if.RS           = '0;
    rf_if.RT           = '0;
    rf_if.RD           = '0;
    rf_if.RegWrite     = 1'b0;
    rf_if.WriteData    = '0;
    tick();
    test_reset();
    test_basic();
    test_r0();
    test_write_disable();
    test_dual_port();
    test_read_during_write();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
